sprite_line_fetcher: RTL and testbench
======================================

# sprite_line_fetcher

Parametrised sprite address counter for the pixel pipeline. Sits between the sprite-attribute registers and the sprite ROM. While a sprite is enabled and the raster enters its window, it emits one ROM address per `clk_pixel` for the current sprite line. It supports configurable sprite width and height, horizontal and vertical mirroring, and mid-line entry, and it flags both end-of-line and end-of-sprite.

## Interface
Parameters:
- `size_x`, 10: pixel_x width.
- `size_y`, 9: pixel_y width; also the width of the y and offset fields.
- `size_address`, 17: ROM address width.
- `sprite_w`, 20: sprite width in pixels (≥2).
- `sprite_h`, 20: sprite height in lines (≥1).

Ports:
- `clk_pixel`  in  1: pixel clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `pixel_x`  in  size_x: current raster column.
- `pixel_y`  in  size_y: current raster line.
- `sprite_datas`  in  32: sprite attribute word.
  - offset at [size_y-1:0].
  - y at [2·size_y-1:size_y].
  - x at [size_x+2·size_y-1:2·size_y].
  - flip_h at the next bit up, flip_v at the bit above that.
  - All remaining bits ignored.
  - Defaults give offset[8:0], y[17:9], x[27:18], flip_h[28], flip_v[29].
- `sprite_on`  in  1: enable for this sprite.
- `memory_address`  out  size_address: registered ROM address.
- `address_valid`  out  1: memory_address is valid this cycle.
- `count_finished`  out  1: one-cycle pulse, coincident with the last address of a line.
- `sprite_finished`  out  1: one-cycle pulse, coincident with the last address of the last sprite line.

## Operation
- FSM has three states.
- **IDLE**
  - Enters COUNT when sprite_on=1 and the pixel is inside the window: x ≤ pixel_x < x+sprite_w and y ≤ pixel_y < y+sprite_h.
  - Window comparisons use size_x+1 / size_y+1 bits, so x+sprite_w never wraps.
  - On entry, latch offset, flip_h and flip_v.
  - On entry, set row = pixel_y−y and col = pixel_x−x. Mid-line entry is legal.
- **COUNT**
  - Each cycle, output the address for (row, col), then col+1.
  - pixel_x is ignored; sprite_datas changes are ignored.
  - When col = sprite_w−1: pulse count_finished (and sprite_finished if row = sprite_h−1), then go to HOLD.
  - If sprite_on=0 is sampled, go to IDLE. That cycle is invalid and no pulse is issued (abort).
- **HOLD**
  - address_valid=0.
  - Stay in HOLD while sprite_on=1. This prevents a re-trigger on the same line.
  - Go to IDLE when sprite_on=0.
- **Address rule**
  - c = flip_h ? sprite_w−1−col : col.
  - r = flip_v ? sprite_h−1−row : row.
  - memory_address = offset·sprite_w·sprite_h + r·sprite_w + c, computed modulo 2^size_address.

## Timing
- Reset (asynchronous, any state, including mid-line):
  - state = IDLE.
  - memory_address, address_valid, count_finished and sprite_finished all 0.
  - Internal counters 0.
- Latency: a qualifying pixel sampled at edge k gives its address, with address_valid=1, after edge k.
  - Subsequent addresses follow on consecutive edges with no gaps.
  - A full line produces exactly sprite_w valid cycles.
- When address_valid=0, memory_address holds its last value.
- Pulses are registered and aligned with the final address of the line.
- If sprite_on falls in the same cycle as col = sprite_w−1, the sprite_on drop wins: the cycle is aborted and no pulse is issued.
- Entry at col = sprite_w−1 gives a single valid cycle, with count_finished asserted in that same cycle.
- The next trigger requires at least one cycle of sprite_on=0 after HOLD.

## Test plan
- **Reset:** assert reset=0 mid-COUNT → all outputs 0 asynchronously. Release, then apply one qualifying pixel → the FSM restarts from IDLE.
- **Basic line:** x=32, y=32, offset=8, no flip, pixel (32,32), sprite_on held 20 cycles → addresses 3200..3219 on consecutive cycles. count_finished on 3219; sprite_finished=0.
- **Row offset and flip_h:** pixel_y=48 (row 16) → addresses 3520..3539. The same line with flip_h=1 → 3539..3520, with count_finished on 3520.
- **flip_v and end of sprite:**
  - pixel_y=48 with flip_v=1 → addresses start at 3260.
  - pixel_y=51 (row 19), no flip → last address 3599. count_finished and sprite_finished both pulse.
- **Mid-line entry and abort:**
  - Enter at pixel_x=45 → 3213..3219 (7 valid cycles).
  - Separately, drop sprite_on after 5 addresses → address_valid=0 next cycle, no pulses, FSM returns to IDLE.
- **Outside window and HOLD:**
  - pixel_x=31 or 52, or pixel_y=52 → address_valid stays 0.
  - Holding sprite_on=1 after count_finished → no second line until sprite_on toggles low.

Source files
------------

// File: rtl/sprite_line_fetcher_if.sv
// Sprite line fetcher bus: raster and attribute inputs,
// registered ROM address and end-of-line/end-of-sprite flags.
interface sprite_line_fetcher_if #(
  parameter int size_x       = 10,
  parameter int size_y       = 9,
  parameter int size_address = 17
);
  logic [size_x-1:0]       pixel_x;
  logic [size_y-1:0]       pixel_y;
  logic [31:0]             sprite_datas;
  logic                    sprite_on;
  logic [size_address-1:0] memory_address;
  logic                    address_valid;
  logic                    count_finished;
  logic                    sprite_finished;

  modport master (
    output pixel_x, pixel_y, sprite_datas, sprite_on,
    input  memory_address, address_valid,
    input  count_finished, sprite_finished
  );

  modport slave (
    input  pixel_x, pixel_y, sprite_datas, sprite_on,
    output memory_address, address_valid,
    output count_finished, sprite_finished
  );
endinterface

// File: rtl/sprite_line_fetcher.sv
// Sprite ROM address generator: one address per pixel clock
// across the current sprite line, with mirroring and mid-line entry.
module sprite_line_fetcher #(
  parameter int size_x       = 10,
  parameter int size_y       = 9,
  parameter int size_address = 17,
  parameter int sprite_w     = 20,
  parameter int sprite_h     = 20
) (
  input  logic                clk_pixel,
  input  logic                reset,
  sprite_line_fetcher_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_t;

  localparam int XL = 2 * size_y;
  localparam int FH = size_x + 2 * size_y;
  localparam int FV = FH + 1;

  localparam logic [31:0] AREA = 32'(sprite_w * sprite_h);
  localparam logic [31:0] WID  = 32'(sprite_w);

  localparam logic [size_x-1:0] COL_LAST = size_x'(sprite_w - 1);
  localparam logic [size_y-1:0] ROW_LAST = size_y'(sprite_h - 1);
  localparam logic [size_x:0]   W_EXT    = (size_x + 1)'(sprite_w);
  localparam logic [size_y:0]   H_EXT    = (size_y + 1)'(sprite_h);

  state_t state, state_d;

  logic [size_y-1:0]       offset_q, offset_d;
  logic                    fh_q, fh_d;
  logic                    fv_q, fv_d;
  logic [size_y-1:0]       row_q, row_d;
  logic [size_x-1:0]       col_q, col_d;
  logic [size_address-1:0] addr_q, addr_d;
  logic                    valid_q, valid_d;
  logic                    cf_q, cf_d;
  logic                    sf_q, sf_d;
  logic                    emit;

  logic [size_y-1:0] a_off;
  logic [size_y-1:0] a_y;
  logic [size_x-1:0] a_x;
  logic [size_x:0]   px_e, x_e;
  logic [size_y:0]   py_e, y_e;
  logic              hit;
  logic              unused_bits;

  assign a_off = bus.sprite_datas[size_y-1:0];
  assign a_y   = bus.sprite_datas[XL-1:size_y];
  assign a_x   = bus.sprite_datas[FH-1:XL];

  assign unused_bits = ^bus.sprite_datas[31:FV+1];

  // Extra top bit keeps x+sprite_w from wrapping near the raster edge
  assign px_e = {1'b0, bus.pixel_x};
  assign x_e  = {1'b0, a_x};
  assign py_e = {1'b0, bus.pixel_y};
  assign y_e  = {1'b0, a_y};

  assign hit = bus.sprite_on
            && px_e >= x_e && px_e < x_e + W_EXT
            && py_e >= y_e && py_e < y_e + H_EXT;

  function automatic logic [size_address-1:0] rom_addr(
    input logic [size_y-1:0] off,
    input logic [size_y-1:0] row,
    input logic [size_x-1:0] col,
    input logic              fh,
    input logic              fv
  );
    logic [size_x-1:0] c;
    logic [size_y-1:0] r;
    c = fh ? COL_LAST - col : col;
    r = fv ? ROW_LAST - row : row;
    return size_address'(32'(off) * AREA
                       + 32'(r) * WID
                       + 32'(c));
  endfunction

  always_comb begin
    state_d  = state;
    offset_d = offset_q;
    fh_d     = fh_q;
    fv_d     = fv_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    valid_d  = 1'b0;
    cf_d     = 1'b0;
    sf_d     = 1'b0;
    emit     = 1'b0;

    unique case (state)
      IDLE: begin
        if (hit) begin
          offset_d = a_off;
          fh_d     = bus.sprite_datas[FH];
          fv_d     = bus.sprite_datas[FV];
          row_d    = bus.pixel_y - a_y;
          col_d    = bus.pixel_x - a_x;
          emit     = 1'b1;
        end
      end
      COUNT: begin
        if (!bus.sprite_on) state_d = IDLE;
        else                emit    = 1'b1;
      end
      HOLD: begin
        if (!bus.sprite_on) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      addr_d  = rom_addr(offset_d, row_d, col_d,
                         fh_d, fv_d);
      valid_d = 1'b1;
      if (col_d == COL_LAST) begin
        cf_d    = 1'b1;
        sf_d    = (row_d == ROW_LAST);
        state_d = HOLD;
      end else begin
        col_d   = col_d + 1'b1;
        state_d = COUNT;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      offset_q <= '0;
      fh_q     <= 1'b0;
      fv_q     <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      cf_q     <= 1'b0;
      sf_q     <= 1'b0;
    end else begin
      state    <= state_d;
      offset_q <= offset_d;
      fh_q     <= fh_d;
      fv_q     <= fv_d;
      row_q    <= row_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      cf_q     <= cf_d;
      sf_q     <= sf_d;
    end
  end

  assign bus.memory_address  = addr_q;
  assign bus.address_valid   = valid_q;
  assign bus.count_finished  = cf_q;
  assign bus.sprite_finished = sf_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Bench for sprite_line_fetcher: directed vector table, corner
// sequences, then random raster traffic against a queue model.
module tb_sprite_line_fetcher;

  localparam int SX = 10;
  localparam int SY = 9;
  localparam int SA = 17;
  localparam int W  = 20;
  localparam int H  = 20;

  logic clk_pixel = 1'b0;
  logic rst_n;

  always #5 clk_pixel = ~clk_pixel;

  sprite_line_fetcher_if #(
    .size_x(SX), .size_y(SY), .size_address(SA)
  ) bus ();

  sprite_line_fetcher #(
    .size_x(SX), .size_y(SY), .size_address(SA),
    .sprite_w(W), .sprite_h(H)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string name;
    int    x, y, off;
    bit    fh, fv;
    int    px, py;
    int    first, step, count;
    bit    sf;
  } vec_t;

  typedef struct {
    int addr;
    bit cf;
    bit sf;
  } ent_t;

  vec_t vecs[$];
  ent_t q[$];

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  function automatic logic [31:0] pack(
    int x, int y, int off, bit fh, bit fv
  );
    return {2'b00, fv, fh, 10'(x), 9'(y), 9'(off)};
  endfunction

  function automatic int ref_addr(
    int off, int row, int col, bit fh, bit fv
  );
    int c, r;
    c = fh ? W - 1 - col : col;
    r = fv ? H - 1 - row : row;
    return (off * W * H + r * W + c) % (1 << SA);
  endfunction

  task automatic set_in(vec_t v);
    bus.sprite_datas = pack(v.x, v.y, v.off, v.fh, v.fv);
    bus.pixel_x = 10'(v.px);
    bus.pixel_y = 9'(v.py);
  endtask

  task automatic chk_out(string nm, bit v, int a,
                         bit cf, bit sf);
    chk({nm, ".valid"}, int'(bus.address_valid), int'(v));
    chk({nm, ".cf"}, int'(bus.count_finished), int'(cf));
    chk({nm, ".sf"}, int'(bus.sprite_finished), int'(sf));
    chk({nm, ".addr"}, int'(bus.memory_address), a);
  endtask

  task automatic add(string n, int px, int py, bit fh,
                     bit fv, int first, int step, int cnt,
                     bit sf, int off = 8, int x = 32,
                     int y = 32);
    vec_t v;
    v.name = n; v.x = x; v.y = y; v.off = off;
    v.fh = fh; v.fv = fv; v.px = px; v.py = py;
    v.first = first; v.step = step; v.count = cnt;
    v.sf = sf;
    vecs.push_back(v);
  endtask

  vec_t b;
  bit   ev, ecf, esf, blocked, on, hit;
  int   ea, x, y, off, px, py;
  bit   fh, fv;

  initial begin
    add("basic",    32, 32, 0, 0, 3200,  1, 20, 0);
    add("row16",    32, 48, 0, 0, 3520,  1, 20, 0);
    add("fliph",    32, 48, 1, 0, 3539, -1, 20, 0);
    add("flipv",    32, 48, 0, 1, 3260,  1, 20, 0);
    add("lastrow",  32, 51, 0, 0, 3580,  1, 20, 1);
    add("fliphv",   32, 51, 1, 1, 3219, -1, 20, 1);
    add("midline",  45, 32, 0, 0, 3213,  1,  7, 0);
    add("lastcol",  51, 32, 0, 0, 3219,  1,  1, 0);
    add("left",     31, 32, 0, 0,    0,  0,  0, 0);
    add("right",    52, 32, 0, 0,    0,  0,  0, 0);
    add("bottom",   32, 52, 0, 0,    0,  0,  0, 0);
    add("top",      32, 31, 0, 0,    0,  0,  0, 0);
    add("wrap",      0,  0, 0, 0, 28928, 1, 20, 0,
        400, 0, 0);

    rst_n = 1'b0;
    bus.sprite_on = 1'b0;
    bus.pixel_x = '0;
    bus.pixel_y = '0;
    bus.sprite_datas = '0;
    #12;
    chk_out("reset", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[k]) begin
      set_in(vecs[k]);
      bus.sprite_on = 1'b1;
      for (int i = 0; i < 25; i++) begin
        bit vv;
        bit last;
        tick();
        vv = i < vecs[k].count;
        last = i == vecs[k].count - 1;
        chk({vecs[k].name, ".valid"},
            int'(bus.address_valid), int'(vv));
        chk({vecs[k].name, ".cf"},
            int'(bus.count_finished), int'(last));
        chk({vecs[k].name, ".sf"},
            int'(bus.sprite_finished),
            int'(last && vecs[k].sf));
        if (vv)
          chk({vecs[k].name, ".addr"},
              int'(bus.memory_address),
              vecs[k].first + vecs[k].step * i);
      end
      bus.sprite_on = 1'b0;
      tick();
      tick();
    end

    b = vecs[0];

    // Asynchronous reset in the middle of a line
    set_in(b);
    bus.sprite_on = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst.addr", int'(bus.memory_address), 3204);
    #2 rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 0, 0, 0, 0);
    bus.sprite_on = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.sprite_on = 1'b1;
    tick();
    chk_out("restart", 1, 3200, 0, 0);
    bus.sprite_on = 1'b0;
    tick();
    tick();

    // Abort after five addresses, then re-trigger from IDLE
    bus.sprite_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort.addr", int'(bus.memory_address),
          3200 + i);
    end
    bus.sprite_on = 1'b0;
    tick();
    chk_out("abort", 0, 3204, 0, 0);
    bus.sprite_on = 1'b1;
    tick();
    chk_out("retrig", 1, 3200, 0, 0);
    bus.sprite_on = 1'b0;
    tick();
    tick();

    // Drop on the final column of the last row
    set_in(vecs[4]);
    bus.sprite_on = 1'b1;
    for (int i = 0; i < 19; i++) tick();
    chk("lastdrop.pre", int'(bus.memory_address), 3598);
    bus.sprite_on = 1'b0;
    tick();
    chk_out("lastdrop", 0, 3598, 0, 0);
    tick();

    // One low cycle after HOLD re-arms the trigger
    set_in(b);
    bus.sprite_on = 1'b1;
    for (int i = 0; i < 23; i++) tick();
    chk_out("hold", 0, 3219, 0, 0);
    bus.sprite_on = 1'b0;
    tick();
    bus.sprite_on = 1'b1;
    tick();
    chk_out("rearm", 1, 3200, 0, 0);
    bus.sprite_on = 1'b0;
    tick();
    tick();

    // Random raster traffic against the queue model
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    ea = 0;
    blocked = 0;
    q.delete();
    x = 100; y = 50; off = 3; fh = 0; fv = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 511);
        off = $urandom_range(0, 511);
        fh = 1'($urandom_range(0, 1));
        fv = 1'($urandom_range(0, 1));
      end
      px = (x + $urandom_range(0, W + 3) - 2) & 1023;
      py = (y + $urandom_range(0, H + 1) - 1) & 511;
      on = $urandom_range(0, 11) != 0;
      bus.sprite_datas = pack(x, y, off, fh, fv);
      bus.pixel_x = 10'(px);
      bus.pixel_y = 9'(py);
      bus.sprite_on = on;
      tick();

      ev = 0; ecf = 0; esf = 0;
      hit = on && px >= x && px < x + W
               && py >= y && py < y + H;
      if (q.size() > 0) begin
        if (!on) q.delete();
        else begin
          ent_t e;
          e = q.pop_front();
          ev = 1; ea = e.addr; ecf = e.cf; esf = e.sf;
          if (q.size() == 0) blocked = 1;
        end
      end else if (blocked) begin
        if (!on) blocked = 0;
      end else if (hit) begin
        for (int c = px - x; c < W; c++) begin
          ent_t e;
          e.addr = ref_addr(off, py - y, c, fh, fv);
          e.cf = c == W - 1;
          e.sf = c == W - 1 && py - y == H - 1;
          q.push_back(e);
        end
        begin
          ent_t e;
          e = q.pop_front();
          ev = 1; ea = e.addr; ecf = e.cf; esf = e.sf;
          if (q.size() == 0) blocked = 1;
        end
      end
      chk_out("rand", ev, ea, ecf, esf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
